// File: rtl/jt12_timer_status.sv
// FM status sources: timer A/B overflow flags, write-busy flag and registered active-low IRQ.
// Timer A also emits a one-clk overflow pulse for CSM key-on.
module jt12_timer_status #(
  parameter int BUSY_CYCLES = 32,
  parameter int TB_PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       write,
  input  logic [9:0] value_A,
  input  logic [7:0] value_B,
  input  logic       load_A,
  input  logic       load_B,
  input  logic       en_irq_A,
  input  logic       en_irq_B,
  input  logic       clr_flag_A,
  input  logic       clr_flag_B,
  output logic       flag_A,
  output logic       flag_B,
  output logic       overflow_A,
  output logic       busy,
  output logic       irq_n
);

  localparam int PW = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TB_PRESCALE - 1);
  localparam logic [7:0]    BUSY_RELOAD = 8'(BUSY_CYCLES);

  logic          r_load_A_q;
  logic          r_load_B_q;
  logic [9:0]    r_cnt_A;
  logic [7:0]    r_cnt_B;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_busy_cnt;
  logic          r_busy;
  logic          r_flag_A;
  logic          r_flag_B;
  logic          r_ovf_A;
  logic          r_irq_n;

  logic w_start_A;
  logic w_start_B;
  logic w_tick_A;
  logic w_tick_B;
  logic w_ovf_A;
  logic w_pre_wrap;
  logic w_ovf_B;

  // A rising load edge reloads the counter and swallows a coincident zero tick.
  assign w_start_A  = load_A & ~r_load_A_q;
  assign w_start_B  = load_B & ~r_load_B_q;
  assign w_tick_A   = load_A & zero & ~w_start_A;
  assign w_tick_B   = load_B & zero & ~w_start_B;
  assign w_ovf_A    = w_tick_A & (r_cnt_A == 10'h3ff);
  assign w_pre_wrap = w_tick_B & (r_pre == PRE_LAST);
  assign w_ovf_B    = w_pre_wrap & (r_cnt_B == 8'hff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_A_q <= 1'b0;
      r_cnt_A    <= 10'd0;
      r_ovf_A    <= 1'b0;
    end else begin
      r_load_A_q <= load_A;
      r_ovf_A    <= w_ovf_A;
      if (w_start_A || w_ovf_A) begin
        r_cnt_A <= value_A;
      end else if (w_tick_A) begin
        r_cnt_A <= r_cnt_A + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_B_q <= 1'b0;
      r_cnt_B    <= 8'd0;
      r_pre      <= '0;
    end else begin
      r_load_B_q <= load_B;
      if (w_start_B) begin
        r_cnt_B <= value_B;
        r_pre   <= '0;
      end else if (w_tick_B) begin
        r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
        if (w_ovf_B) begin
          r_cnt_B <= value_B;
        end else if (w_pre_wrap) begin
          r_cnt_B <= r_cnt_B + 8'd1;
        end
      end
    end
  end

  // Set beats clear when both land on the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_A <= 1'b0;
      r_flag_B <= 1'b0;
      r_irq_n  <= 1'b1;
    end else begin
      if (w_ovf_A && en_irq_A) begin
        r_flag_A <= 1'b1;
      end else if (clr_flag_A) begin
        r_flag_A <= 1'b0;
      end
      if (w_ovf_B && en_irq_B) begin
        r_flag_B <= 1'b1;
      end else if (clr_flag_B) begin
        r_flag_B <= 1'b0;
      end
      r_irq_n <= ~(r_flag_A | r_flag_B);
    end
  end

  // Busy drops on the first cen cycle after the count has reached zero; a write always reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_busy_cnt <= 8'd0;
    end else if (write) begin
      r_busy     <= 1'b1;
      r_busy_cnt <= BUSY_RELOAD;
    end else if (r_busy && cen) begin
      if (r_busy_cnt == 8'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_busy_cnt <= r_busy_cnt - 8'd1;
      end
    end
  end

  assign flag_A     = r_flag_A;
  assign flag_B     = r_flag_B;
  assign overflow_A = r_ovf_A;
  assign busy       = r_busy;
  assign irq_n      = r_irq_n;

endmodule
